video_sprite_loader: RTL and testbench

Bus initiator that uploads one sprite image from system memory into the sprite overlay peripheral, then programs its position and visibility registers.
- It reads packed 8-bit pixels over a 32-bit memory read port and issues single-word writes to the sprite peripheral's slave port.
- The register update can be deferred to vertical blank, so position, visibility and image change together without tearing.
- Sits between the CPU-visible control logic and the sprite overlay peripheral.

---
 rtl/video_sprite_loader.sv | 184 ++++++++++++++++++
 tb/tb_video_sprite_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_sprite_loader.sv
// Purpose : bus initiator that copies one packed 8-bit sprite image from memory
//           into the sprite overlay, then writes its position/visibility registers.
// Latency : per word 1 read + 4 single-byte writes; every transaction is
//           followed by at least one idle request cycle.
// Backpressure: request/address/wdata are held until the slave's ready is sampled.
// Ports:
//   i_clock, i_reset           rising-edge clock, async active-high reset
//   i_start + latched args     i_src_address, i_pos_x, i_pos_y, i_visible, i_sync_vblank
//   i_video_vblank             vertical blank used when register update is deferred
//   o_busy, o_done             run in progress / one-cycle completion pulse
//   o_mem_*, i_mem_*           32-bit memory read port
//   o_sprite_*, i_sprite_ready sprite peripheral write port
module video_sprite_loader #(
  parameter int          WIDTH       = 32,
  parameter int          HEIGHT      = 32,
  parameter logic [31:0] SPRITE_BASE = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_src_address,
  input  logic [10:0] i_pos_x,
  input  logic [10:0] i_pos_y,
  input  logic        i_visible,
  input  logic        i_sync_vblank,
  input  logic        i_video_vblank,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_mem_request,
  output logic [31:0] o_mem_address,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_sprite_request,
  output logic [31:0] o_sprite_address,
  output logic [31:0] o_sprite_wdata,
  input  logic        i_sprite_ready
);

  localparam int          PIXELS   = WIDTH * HEIGHT;
  localparam logic [12:0] LAST_IDX = 13'(PIXELS);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_WAIT_VB, S_REG, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] pix_idx_q;
  logic [1:0]  byte_cnt_q;
  logic [1:0]  reg_cnt_q;
  logic [31:0] rd_addr_q;
  logic [31:0] word_q;
  logic [10:0] pos_x_q;
  logic [10:0] pos_y_q;
  logic        visible_q;
  logic        sync_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        spr_req_q;
  logic [31:0] spr_addr_q;
  logic [31:0] spr_wdata_q;

  logic        mem_fire;
  logic        spr_fire;
  logic        last_pix;
  logic [7:0]  cur_byte;
  logic [31:0] data_addr;
  logic [31:0] reg_addr;
  logic [31:0] reg_data;

  // A ready only counts while our own request is up.
  assign mem_fire = mem_req_q & i_mem_ready;
  assign spr_fire = spr_req_q & i_sprite_ready;
  assign last_pix = (pix_idx_q + 13'd1) == LAST_IDX;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cur_byte  = word_q[{byte_cnt_q, 3'b000} +: 8];
    // Index field stays below 0x4000, so OR-ing in the image window is safe.
    data_addr = SPRITE_BASE | 32'h0000_4000 | {17'h0, pix_idx_q, 2'b00};
    reg_addr  = SPRITE_BASE + {28'h0, reg_cnt_q, 2'b00};
    case (reg_cnt_q)
      2'd0:    reg_data = {21'h0, pos_x_q};
      2'd1:    reg_data = {21'h0, pos_y_q};
      default: reg_data = {31'h0, visible_q};
    endcase
    case (state_q)
      S_IDLE:    if (i_start) state_d = S_READ;
      S_READ:    if (mem_fire) state_d = S_WRITE;
      S_WRITE: begin
        if (spr_fire && byte_cnt_q == 2'd3) begin
          if (last_pix) state_d = sync_q ? S_WAIT_VB : S_REG;
          else          state_d = S_READ;
        end
      end
      S_WAIT_VB: if (i_video_vblank) state_d = S_REG;
      S_REG:     if (spr_fire && reg_cnt_q == 2'd2) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Each transaction: raise request on entry, drop it on the ready edge. The
  // dropped cycle guarantees the mandatory low gap before the next request.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      pix_idx_q   <= '0;
      byte_cnt_q  <= '0;
      reg_cnt_q   <= '0;
      rd_addr_q   <= '0;
      word_q      <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      visible_q   <= 1'b0;
      sync_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      spr_req_q   <= 1'b0;
      spr_addr_q  <= '0;
      spr_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            rd_addr_q  <= i_src_address;
            pos_x_q    <= i_pos_x;
            pos_y_q    <= i_pos_y;
            visible_q  <= i_visible;
            sync_q     <= i_sync_vblank;
            pix_idx_q  <= '0;
            byte_cnt_q <= '0;
            reg_cnt_q  <= '0;
          end
        end
        S_READ: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= rd_addr_q;
          end else if (i_mem_ready) begin
            mem_req_q  <= 1'b0;
            word_q     <= i_mem_rdata;
            rd_addr_q  <= rd_addr_q + 32'd4;
            byte_cnt_q <= '0;
          end
        end
        S_WRITE: begin
          if (!spr_req_q) begin
            spr_req_q   <= 1'b1;
            spr_addr_q  <= data_addr;
            spr_wdata_q <= {24'h0, cur_byte};
          end else if (i_sprite_ready) begin
            spr_req_q  <= 1'b0;
            pix_idx_q  <= pix_idx_q + 13'd1;
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        S_REG: begin
          if (!spr_req_q) begin
            spr_req_q   <= 1'b1;
            spr_addr_q  <= reg_addr;
            spr_wdata_q <= reg_data;
          end else if (i_sprite_ready) begin
            spr_req_q <= 1'b0;
            reg_cnt_q <= reg_cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done           = (state_q == S_DONE);
  assign o_mem_request    = mem_req_q;
  assign o_mem_address    = mem_addr_q;
  assign o_sprite_request = spr_req_q;
  assign o_sprite_address = spr_addr_q;
  assign o_sprite_wdata   = spr_wdata_q;

endmodule

// File: tb/tb_video_sprite_loader.sv
// Bench for video_sprite_loader: a 4x4 instance checked against a transaction
// scoreboard every cycle, plus a 2x2 instance with a non-zero base address.
module tb_video_sprite_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, start_b;
  logic [31:0] src;
  logic [10:0] pos_x, pos_y;
  logic        visible, sync, vblank;

  logic        busy, done, mem_req, mem_ready, spr_req, spr_ready;
  logic [31:0] mem_addr, mem_rdata, spr_addr, spr_wdata;
  logic        busy_b, done_b, mem_req_b, mem_ready_b, spr_req_b, spr_ready_b;
  logic [31:0] mem_addr_b, mem_rdata_b, spr_addr_b, spr_wdata_b;

  video_sprite_loader #(.WIDTH(4), .HEIGHT(4), .SPRITE_BASE(32'h0)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_src_address(src),
    .i_pos_x(pos_x), .i_pos_y(pos_y), .i_visible(visible), .i_sync_vblank(sync),
    .i_video_vblank(vblank), .o_busy(busy), .o_done(done),
    .o_mem_request(mem_req), .o_mem_address(mem_addr), .i_mem_rdata(mem_rdata),
    .i_mem_ready(mem_ready), .o_sprite_request(spr_req), .o_sprite_address(spr_addr),
    .o_sprite_wdata(spr_wdata), .i_sprite_ready(spr_ready));

  video_sprite_loader #(.WIDTH(2), .HEIGHT(2), .SPRITE_BASE(32'h0004_0000)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(start_b), .i_src_address(src),
    .i_pos_x(pos_x), .i_pos_y(pos_y), .i_visible(visible), .i_sync_vblank(sync),
    .i_video_vblank(vblank), .o_busy(busy_b), .o_done(done_b),
    .o_mem_request(mem_req_b), .o_mem_address(mem_addr_b), .i_mem_rdata(mem_rdata_b),
    .i_mem_ready(mem_ready_b), .o_sprite_request(spr_req_b), .o_sprite_address(spr_addr_b),
    .o_sprite_wdata(spr_wdata_b), .i_sprite_ready(spr_ready_b));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%08h, expected none", name, act);
  endtask

  // Memory image: byte at address a is (a - 0x1000) mod 256.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'h1000;
    return {d[7:0] + 8'd3, d[7:0] + 8'd2, d[7:0] + 8'd1, d[7:0]};
  endfunction

  // ---------------- scoreboard for the 4x4 instance ----------------
  logic [31:0] exp_rd[$];
  logic [63:0] exp_wr[$];
  logic [31:0] log_addr[$], log_data[$];
  bit          exp_busy = 0;
  int          done_cnt = 0;
  int          wr_fires = 0;
  int          rd_fires = 0;

  task automatic build(input logic [31:0] s, input logic [10:0] px, input logic [10:0] py,
                       input logic vis);
    logic [31:0] w;
    logic [7:0]  b;
    for (int k = 0; k < 4; k++) exp_rd.push_back(s + 32'(4 * k));
    for (int i = 0; i < 16; i++) begin
      w = mem_word(s + 32'(4 * (i / 4)));
      b = w[8 * (i % 4) +: 8];
      exp_wr.push_back({32'h4000 + 32'(4 * i), 24'h0, b});
    end
    exp_wr.push_back({32'h0, 21'h0, px});
    exp_wr.push_back({32'h4, 21'h0, py});
    exp_wr.push_back({32'h8, 31'h0, vis});
  endtask

  task automatic clear_model();
    exp_rd.delete(); exp_wr.delete(); log_addr.delete(); log_data.delete();
    wr_fires = 0; rd_fires = 0; exp_busy = 0;
  endtask

  // Slave responders: ready after *_delay waiting cycles; optional stray
  // ready pulses while the request is low.
  int mem_delay = 0, spr_delay = 0;
  bit spurious = 0;
  int mcnt = 0, scnt = 0;

  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (mcnt >= mem_delay) begin mem_ready = 1'b1; mem_rdata = mem_word(mem_addr); end
      else begin mem_ready = 1'b0; mcnt++; end
    end else begin
      mcnt = 0;
      mem_ready = spurious && ($urandom_range(0, 1) == 1);
      mem_rdata = 32'hDEAD_BEEF;
    end
    if (spr_req) begin
      if (scnt >= spr_delay) spr_ready = 1'b1;
      else begin spr_ready = 1'b0; scnt++; end
    end else begin
      scnt = 0;
      spr_ready = spurious && ($urandom_range(0, 1) == 1);
    end
    mem_ready_b = mem_req_b;
    mem_rdata_b = mem_word(mem_addr_b);
    spr_ready_b = spr_req_b;
  end

  // Per-cycle compare for the 4x4 instance.
  logic        pm_req = 0, pm_rdy = 0, ps_req = 0, ps_rdy = 0;
  logic [31:0] pm_addr = 0, ps_addr = 0, ps_data = 0;
  logic [63:0] e;

  always @(negedge clk) begin
    if (rst) begin
      pm_req = 0; ps_req = 0;
    end else begin
      check("no_overlap", {31'h0, mem_req & spr_req}, 32'h0);
      if (pm_req && !pm_rdy) begin
        check("mem_hold_req", {31'h0, mem_req}, 32'h1);
        check("mem_hold_addr", mem_addr, pm_addr);
      end
      if (ps_req && !ps_rdy) begin
        check("spr_hold_req", {31'h0, spr_req}, 32'h1);
        check("spr_hold_addr", spr_addr, ps_addr);
        check("spr_hold_data", spr_wdata, ps_data);
      end
      if (mem_req && mem_ready) begin
        rd_fires++;
        if (exp_rd.size() == 0) fail_now("extra_read", mem_addr);
        else check("read_addr", mem_addr, exp_rd.pop_front());
      end
      if (spr_req && spr_ready) begin
        wr_fires++;
        log_addr.push_back(spr_addr);
        log_data.push_back(spr_wdata);
        if (exp_wr.size() == 0) fail_now("extra_write", spr_addr);
        else begin
          e = exp_wr.pop_front();
          check("write_addr", spr_addr, e[63:32]);
          check("write_data", spr_wdata, e[31:0]);
        end
      end
      if (done) begin
        if (!exp_busy) fail_now("spurious_done", {31'h0, done});
        check("done_busy_low", {31'h0, busy}, 32'h0);
        check("done_reads_left", exp_rd.size(), 0);
        check("done_writes_left", exp_wr.size(), 0);
        done_cnt++;
        exp_busy = 0;
      end else begin
        check("busy", {31'h0, busy}, {31'h0, exp_busy});
      end
      pm_req = mem_req; pm_rdy = mem_ready; pm_addr = mem_addr;
      ps_req = spr_req; ps_rdy = spr_ready; ps_addr = spr_addr; ps_data = spr_wdata;
    end
  end

  // Transaction log for the 2x2 instance.
  int          rdb_cnt = 0, doneb_cnt = 0;
  logic [31:0] rdb_addr = 0;
  logic [31:0] logb_addr[$], logb_data[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_b && mem_ready_b) begin rdb_cnt++; rdb_addr = mem_addr_b; end
      if (spr_req_b && spr_ready_b) begin
        logb_addr.push_back(spr_addr_b);
        logb_data.push_back(spr_wdata_b);
      end
      if (done_b) doneb_cnt++;
    end
  end

  task automatic start_run(input logic [31:0] s, input logic [10:0] px, input logic [10:0] py,
                           input logic vis, input logic sy);
    src = s; pos_x = px; pos_y = py; visible = vis; sync = sy; start = 1'b1;
    build(s, px, py, vis);
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0, c;
    d0 = done_cnt; c = 0;
    while (done_cnt == d0 && c < budget) begin @(posedge clk); #1; c++; end
    if (done_cnt == d0) fail_now(name, c);
    else begin
      check("post_done_pulse", {31'h0, done}, 32'h0);
      check("post_done_busy", {31'h0, busy}, 32'h0);
    end
  endtask

  task automatic check_scn1_literals(input string tag);
    check({tag, "_reads"}, rd_fires, 4);
    check({tag, "_writes"}, wr_fires, 19);
    if (log_addr.size() == 19) begin
      check({tag, "_w0_data"}, log_data[0], 32'h0);
      check({tag, "_w15_addr"}, log_addr[15], 32'h403C);
      check({tag, "_w15_data"}, log_data[15], 32'h0F);
      check({tag, "_posx"}, log_data[16], 32'd100);
      check({tag, "_posy_addr"}, log_addr[17], 32'h4);
      check({tag, "_posy"}, log_data[17], 32'd50);
      check({tag, "_vis_addr"}, log_addr[18], 32'h8);
      check({tag, "_vis"}, log_data[18], 32'd1);
    end
  endtask

  initial begin
    int c, viol, d0;
    rst = 1'b1; start = 0; start_b = 0; src = 0; pos_x = 0; pos_y = 0;
    visible = 0; sync = 0; vblank = 0;
    mem_ready = 0; spr_ready = 0; mem_rdata = 0;
    mem_ready_b = 0; spr_ready_b = 0; mem_rdata_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_spr_req", {31'h0, spr_req}, 32'h0);
    check("rst_spr_addr", spr_addr, 32'h0);
    check("rst_spr_wdata", spr_wdata, 32'h0);
    check("rst_b_busy", {31'h0, busy_b}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic run, zero-wait slaves
    clear_model();
    start_run(32'h1000, 11'd100, 11'd50, 1'b1, 1'b0);
    wait_done(1000, "scn1_timeout");
    check_scn1_literals("scn1");
    check("scn1_done_cnt", done_cnt, 1);

    // 2: deferred register update held off by vblank
    clear_model();
    start_run(32'h1000, 11'd100, 11'd50, 1'b1, 1'b1);
    c = 0;
    while (wr_fires < 16 && c < 1000) begin @(posedge clk); #1; c++; end
    if (wr_fires < 16) fail_now("scn2_data_timeout", wr_fires);
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (mem_req || spr_req || !busy) viol++;
    end
    check("scn2_vb_hold_viol", viol, 0);
    check("scn2_writes_before_vb", wr_fires, 16);
    @(posedge clk); #1;
    vblank = 1'b1;
    wait_done(100, "scn2_timeout");
    vblank = 1'b0;
    check_scn1_literals("scn2");

    // 3: slow slaves with stray ready pulses while idle
    clear_model();
    mem_delay = 7; spr_delay = 3; spurious = 1;
    start_run(32'h1000, 11'd100, 11'd50, 1'b1, 1'b0);
    wait_done(3000, "scn3_timeout");
    check_scn1_literals("scn3");
    mem_delay = 0; spr_delay = 0; spurious = 0;
    @(posedge clk); #1;

    // 4: restart and input changes during a run are ignored
    clear_model();
    start_run(32'h1000, 11'd100, 11'd50, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; src = 32'h8000; pos_x = 11'd7; pos_y = 11'd9; visible = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; pos_x = 11'd555;
    wait_done(1000, "scn4_timeout");
    check_scn1_literals("scn4");

    // 5: reset during the 9th data write
    clear_model();
    start_run(32'h1000, 11'd100, 11'd50, 1'b1, 1'b0);
    c = 0;
    while (!(wr_fires == 8 && spr_req) && c < 1000) begin @(posedge clk); #1; c++; end
    check("scn5_reached_w9", wr_fires, 8);
    #2;
    rst = 1'b1;
    #1;
    check("scn5_rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("scn5_rst_spr_req", {31'h0, spr_req}, 32'h0);
    check("scn5_rst_busy", {31'h0, busy}, 32'h0);
    clear_model();
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scn5_no_done", done_cnt, d0);
    start_run(32'h1000, 11'd100, 11'd50, 1'b1, 1'b0);
    wait_done(1000, "scn5_timeout");
    check_scn1_literals("scn5");

    // 6: 2x2 sprite, visible=0, base 0x40000
    src = 32'h2000; pos_x = 11'd3; pos_y = 11'd4; visible = 1'b0; sync = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    c = 0;
    while (doneb_cnt == 0 && c < 500) begin @(posedge clk); #1; c++; end
    check("scn6_done", doneb_cnt, 1);
    check("scn6_reads", rdb_cnt, 1);
    check("scn6_read_addr", rdb_addr, 32'h2000);
    check("scn6_writes", logb_addr.size(), 7);
    if (logb_addr.size() == 7) begin
      check("scn6_w0_addr", logb_addr[0], 32'h0004_4000);
      check("scn6_w3_addr", logb_addr[3], 32'h0004_400C);
      check("scn6_w3_data", logb_data[3], 32'h03);
      check("scn6_posx_addr", logb_addr[4], 32'h0004_0000);
      check("scn6_posx", logb_data[4], 32'd3);
      check("scn6_vis_addr", logb_addr[6], 32'h0004_0008);
      check("scn6_vis", logb_data[6], 32'h0);
    end
    check("scn6_busy_after", {31'h0, busy_b}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
